water_flow_controller: RTL

Drives the inlet valve and drain pump so the drum water level reaches a commanded target. It is the actuating side of the water path; WaterFlowMonitor is the observing side. It issues `mode` and a synchronous clear to WaterFlowMonitor and aborts on its `error_flag`. It sits between the wash-cycle sequencer (start/done handshake) and the valve/pump drivers.

---
 rtl/water_pkg.sv | 23 ++
 rtl/flow_timer.sv | 31 +++
 rtl/water_flow_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/water_pkg.sv
// Shared definitions for the drum water path: controller states, fault codes
// and the monitor mode encoding.
package water_pkg;

  localparam int LEVEL_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FILL   = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_MONITOR = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  localparam logic MODE_FILL  = 1'b1;
  localparam logic MODE_DRAIN = 1'b0;

endpackage

// File: rtl/flow_timer.sv
// Loadable saturating down-counter shared by the timeout and settle phases.
// expired is high during the cycle whose decrement brings the count to zero.
module flow_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count_r;

  // Count register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r <= CNT_W'(1));

endmodule

// File: rtl/water_flow_controller.sv
// Drives the inlet valve and drain pump until the drum reaches a commanded
// level, coordinating clear/mode with the flow monitor and aborting on its error.
module water_flow_controller
  import water_pkg::*;
#(
  parameter int LEVEL_W        = LEVEL_W_DEFAULT,
  parameter int MAX_LEVEL      = 900,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cmd_fill,
  input  logic [LEVEL_W-1:0] target_level,
  input  logic               abort,
  input  logic               clear_fault,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic               error_flag,
  output logic               inlet_valve,
  output logic               drain_pump,
  output logic               mode,
  output logic               monitor_clear,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code
);

  state_t             state_r, next_state_s;
  logic [LEVEL_W-1:0] tgt_r, tgt_next_s, clamped_s;
  logic               cmd_fill_r, cmd_next_s;
  logic               first_r;
  logic               timer_load_s, timer_en_s, timer_expired_s;
  logic [CNT_W-1:0]   timer_value_s;
  logic               inlet_next_s, drain_next_s, mode_next_s, mclr_next_s;
  logic               busy_next_s, done_next_s, fault_next_s;
  logic [1:0]         code_next_s;
  logic               reached_fill_s, reached_drain_s;

  assign clamped_s = (target_level > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                          : target_level;
  assign reached_fill_s  = (water_level_sensor >= tgt_r);
  assign reached_drain_s = (water_level_sensor <= tgt_r);

  flow_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_s),
    .enable     (timer_en_s),
    .load_value (timer_value_s),
    .expired    (timer_expired_s)
  );

  // Next-state logic; within FILL/DRAIN the order is target > abort > error > timeout.
  always_comb begin
    next_state_s  = state_r;
    tgt_next_s    = tgt_r;
    cmd_next_s    = cmd_fill_r;
    timer_load_s  = 1'b0;
    timer_value_s = CNT_W'(TIMEOUT_CYCLES);
    done_next_s   = 1'b0;
    code_next_s   = fault_code;
    timer_en_s    = (state_r == FILL) || (state_r == DRAIN) || (state_r == SETTLE);
    case (state_r)
      IDLE: begin
        if (start) begin
          tgt_next_s = clamped_s;
          cmd_next_s = cmd_fill;
          if ((cmd_fill && (water_level_sensor >= clamped_s)) ||
              (!cmd_fill && (water_level_sensor <= clamped_s))) begin
            next_state_s  = SETTLE;
            timer_load_s  = 1'b1;
            timer_value_s = CNT_W'(SETTLE_CYCLES);
          end else begin
            next_state_s = CLEAR;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        if (abort) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = cmd_fill_r ? FILL : DRAIN;
          timer_load_s = 1'b1;
        end
      end
      FILL, DRAIN: begin
        if ((state_r == FILL) ? reached_fill_s : reached_drain_s) begin
          next_state_s  = SETTLE;
          timer_load_s  = 1'b1;
          timer_value_s = CNT_W'(SETTLE_CYCLES);
        end else if (abort) begin
          next_state_s = IDLE;
        end else if (error_flag && !first_r) begin
          next_state_s = FAULT;
          code_next_s  = FC_MONITOR;
        end else if (timer_expired_s) begin
          next_state_s = FAULT;
          code_next_s  = FC_TIMEOUT;
        end else begin
          next_state_s = state_r;
        end
      end
      SETTLE: begin
        if (abort) begin
          next_state_s = IDLE;
        end else if (timer_expired_s) begin
          next_state_s = IDLE;
          done_next_s  = 1'b1;
        end else begin
          next_state_s = SETTLE;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          next_state_s = IDLE;
          code_next_s  = FC_NONE;
        end else begin
          next_state_s = FAULT;
        end
      end
      default: begin
        next_state_s = IDLE;
        code_next_s  = FC_NONE;
      end
    endcase
  end

  // Output values derived from the upcoming state so they register in step with it.
  always_comb begin
    inlet_next_s = (next_state_s == FILL);
    drain_next_s = (next_state_s == DRAIN);
    mclr_next_s  = (next_state_s == CLEAR);
    fault_next_s = (next_state_s == FAULT);
    busy_next_s  = (next_state_s != IDLE) && (next_state_s != FAULT);
    mode_next_s  = mode;
    case (next_state_s)
      CLEAR:   mode_next_s = cmd_next_s ? MODE_FILL : MODE_DRAIN;
      FILL:    mode_next_s = MODE_FILL;
      DRAIN:   mode_next_s = MODE_DRAIN;
      default: mode_next_s = mode;
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      tgt_r         <= {LEVEL_W{1'b0}};
      cmd_fill_r    <= 1'b0;
      first_r       <= 1'b0;
      inlet_valve   <= 1'b0;
      drain_pump    <= 1'b0;
      mode          <= MODE_FILL;
      monitor_clear <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= FC_NONE;
    end else begin
      state_r       <= next_state_s;
      tgt_r         <= tgt_next_s;
      cmd_fill_r    <= cmd_next_s;
      first_r       <= (state_r == CLEAR);
      inlet_valve   <= inlet_next_s;
      drain_pump    <= drain_next_s;
      mode          <= mode_next_s;
      monitor_clear <= mclr_next_s;
      busy          <= busy_next_s;
      done          <= done_next_s;
      fault         <= fault_next_s;
      fault_code    <= code_next_s;
    end
  end

endmodule
